// File: rtl/mem_wb_stage_pkg.sv
// Shared constants, widths and opcode classification for the MEM/WB stage.
package mem_wb_stage_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int REG_W  = 3;
  localparam int OP_W   = 6;
  localparam int FLAG_W = 2;

  localparam logic [OP_W-1:0] OP_LOAD    = 6'b100000;
  localparam logic [OP_W-1:0] OP_STORE   = 6'b100001;
  localparam logic [OP_W-1:0] OP_NOP     = 6'b111111;
  localparam logic [OP_W-1:0] OP_ALU_MIN = 6'b000000;
  localparam logic [OP_W-1:0] OP_ALU_MAX = 6'b011111;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_NOP
  } op_class_e;

  // Every code that is not a memory op or NOP retires through the ALU path.
  function automatic op_class_e classify(input logic [OP_W-1:0] op);
    case (op)
      OP_LOAD:  classify = CLS_LOAD;
      OP_STORE: classify = CLS_STORE;
      OP_NOP:   classify = CLS_NOP;
      default:  classify = CLS_ALU;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Data memory: synchronous write port, asynchronous read port, never reset.
module data_mem
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: data-memory access, register write-back, flags and retire count.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ex,
  input  logic [OP_W-1:0]   op_ex,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] DM_data,
  input  logic [FLAG_W-1:0] flag_ex,
  input  logic [REG_W-1:0]  rd_ex,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [FLAG_W-1:0] flag_wb,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] instr_cnt
);

  op_class_e         cls;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_we;

  logic              wb_en_q,     wb_en_d;
  logic [REG_W-1:0]  wb_addr_q,   wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,   wb_data_d;
  logic [FLAG_W-1:0] flag_wb_q,   flag_wb_d;
  logic [DATA_W-1:0] data_out_q,  data_out_d;
  logic [DATA_W-1:0] instr_cnt_q, instr_cnt_d;

  assign cls     = classify(op_ex);
  assign dm_addr = ans_ex[ADDR_W-1:0];
  // Gating with reset keeps a store that lands on a reset edge out of memory.
  assign dm_we   = valid_ex && (cls == CLS_STORE) && reset;

  data_mem #(.DEPTH(DM_DEPTH)) u_data_mem (
    .clk   (clk),
    .we    (dm_we),
    .waddr (dm_addr),
    .wdata (DM_data),
    .raddr (dm_addr),
    .rdata (dm_rdata)
  );

  always_comb begin
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    flag_wb_d   = flag_wb_q;
    data_out_d  = data_out_q;
    instr_cnt_d = instr_cnt_q;
    if (valid_ex) begin
      if (cls != CLS_NOP) begin
        instr_cnt_d = instr_cnt_q + 16'd1;
      end
      case (cls)
        CLS_ALU: begin
          wb_en_d   = 1'b1;
          wb_addr_d = rd_ex;
          wb_data_d = ans_ex;
          flag_wb_d = flag_ex;
        end
        CLS_LOAD: begin
          wb_en_d    = 1'b1;
          wb_addr_d  = rd_ex;
          wb_data_d  = dm_rdata;
          data_out_d = dm_rdata;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      flag_wb_q   <= '0;
      data_out_q  <= '0;
      instr_cnt_q <= '0;
    end else begin
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      flag_wb_q   <= flag_wb_d;
      data_out_q  <= data_out_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign flag_wb   = flag_wb_q;
  assign data_out  = data_out_q;
  assign instr_cnt = instr_cnt_q;

endmodule
